tr_manual_pulse_gen: RTL

TR_MANUAL_PULSE_GEN -- requirements
Module: tr_manual_pulse_gen

---
 rtl/tr_pkg.sv | 15 +
 rtl/pulse_timer.sv | 37 +++
 rtl/tr_manual_pulse_gen.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/tr_pkg.sv
// Shared definitions for the manual step/dir pulse generator.
// Holds the default bus width, the FSM state type and the period floor.
package tr_pkg;

   localparam int unsigned TP_WIDTH_DEF = 32;
   localparam int unsigned P_MIN        = 2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARM,
      S_RUN_CONT,
      S_RUN_N
   } state_t;

endpackage

// File: rtl/pulse_timer.sv
// Phase counter for one step period: high for the first half,
// completion strobe on the last phase cycle of each period.
module pulse_timer #(
   parameter int unsigned W = 32
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_run,
   input  logic [W-1:0] i_period,
   output logic         o_cmpl,
   output logic         o_step_nxt
);

   logic [W-1:0] r_ph;
   logic [W-1:0] w_ph_nxt;

   assign o_cmpl = i_run && (r_ph == i_period - W'(1));

   // phase restarts at 0 whenever the train is not advancing
   always_comb begin
      w_ph_nxt = '0;
      if (i_run && !o_cmpl) begin
         w_ph_nxt = r_ph + W'(1);
      end
   end

   assign o_step_nxt = w_ph_nxt < (i_period >> 1);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ph <= '0;
      end else begin
         r_ph <= w_ph_nxt;
      end
   end

endmodule

// File: rtl/tr_manual_pulse_gen.sv
// Manual step/dir pulse-train generator: continuous or N-pulse trains,
// period and direction latched at each start command.
module tr_manual_pulse_gen
   import tr_pkg::*;
#(
   parameter int unsigned WIDTH_TP = TP_WIDTH_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                start_N,
   input  logic                stop,
   input  logic                dir_MANUAL,
   input  logic                count_MANUAL,
   input  logic [WIDTH_TP-1:0] period_MANUAL,
   input  logic [WIDTH_TP-1:0] PULSE_NUMBER,
   output logic                step,
   output logic                dir,
   output logic                busy,
   output logic                done,
   output logic [WIDTH_TP-1:0] pulse_cnt
);

   localparam logic [WIDTH_TP-1:0] C_PMIN = WIDTH_TP'(P_MIN);
   localparam logic [WIDTH_TP-1:0] C_ONE  = WIDTH_TP'(1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_mode_n;
   logic                w_mode_n_nxt;
   logic [WIDTH_TP-1:0] r_p;
   logic [WIDTH_TP-1:0] w_p_nxt;
   logic [WIDTH_TP-1:0] r_n;
   logic [WIDTH_TP-1:0] w_n_nxt;
   logic [WIDTH_TP-1:0] r_rem;
   logic [WIDTH_TP-1:0] w_rem_nxt;
   logic [WIDTH_TP-1:0] r_cnt;
   logic [WIDTH_TP-1:0] w_cnt_nxt;
   logic                r_step;
   logic                w_step_nxt;
   logic                r_dir;
   logic                w_dir_nxt;
   logic                r_done;
   logic                w_done_nxt;
   logic                r_busy;
   logic                w_run;
   logic                w_cmpl;
   logic                w_step_tmr;

   pulse_timer #(
      .W (WIDTH_TP)
   ) u_timer (
      .i_clk      (clk),
      .i_rst_n    (rst),
      .i_run      (w_run),
      .i_period   (r_p),
      .o_cmpl     (w_cmpl),
      .o_step_nxt (w_step_tmr)
   );

   always_comb begin
      w_state_nxt  = r_state;
      w_mode_n_nxt = r_mode_n;
      w_p_nxt      = r_p;
      w_n_nxt      = r_n;
      w_rem_nxt    = r_rem;
      w_cnt_nxt    = r_cnt;
      w_step_nxt   = r_step;
      w_dir_nxt    = r_dir;
      w_done_nxt   = 1'b0;
      w_run        = 1'b0;
      if (stop) begin
         if (r_state != S_IDLE) begin
            w_state_nxt = S_IDLE;
            w_step_nxt  = 1'b0;
         end
      end else if (start_N || start) begin
         w_state_nxt  = S_ARM;
         w_mode_n_nxt = start_N;
         w_p_nxt      = (period_MANUAL < C_PMIN) ? C_PMIN : period_MANUAL;
         w_n_nxt      = PULSE_NUMBER;
         w_dir_nxt    = dir_MANUAL;
         w_cnt_nxt    = '0;
         w_step_nxt   = 1'b0;
      end else begin
         unique case (r_state)
            S_ARM: begin
               if (r_mode_n && (r_n == '0)) begin
                  w_state_nxt = S_IDLE;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_state_nxt = r_mode_n ? S_RUN_N : S_RUN_CONT;
                  w_rem_nxt   = r_n;
                  w_step_nxt  = w_step_tmr;
               end
            end
            S_RUN_CONT: begin
               w_run      = 1'b1;
               w_step_nxt = w_step_tmr;
               if (w_cmpl && count_MANUAL) begin
                  w_cnt_nxt = r_cnt + C_ONE;
               end
            end
            S_RUN_N: begin
               w_run      = 1'b1;
               w_step_nxt = w_step_tmr;
               if (w_cmpl && count_MANUAL) begin
                  w_cnt_nxt = r_cnt + C_ONE;
               end
               if (w_cmpl) begin
                  w_rem_nxt = r_rem - C_ONE;
                  if (r_rem == C_ONE) begin
                     w_state_nxt = S_IDLE;
                     w_done_nxt  = 1'b1;
                     w_step_nxt  = 1'b0;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_mode_n <= 1'b0;
         r_p      <= '0;
         r_n      <= '0;
         r_rem    <= '0;
         r_cnt    <= '0;
         r_step   <= 1'b0;
         r_dir    <= 1'b0;
         r_done   <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_mode_n <= w_mode_n_nxt;
         r_p      <= w_p_nxt;
         r_n      <= w_n_nxt;
         r_rem    <= w_rem_nxt;
         r_cnt    <= w_cnt_nxt;
         r_step   <= w_step_nxt;
         r_dir    <= w_dir_nxt;
         r_done   <= w_done_nxt;
         r_busy   <= (w_state_nxt != S_IDLE);
      end
   end

   assign step      = r_step;
   assign dir       = r_dir;
   assign busy      = r_busy;
   assign done      = r_done;
   assign pulse_cnt = r_cnt;

endmodule
